// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared types and helpers for the binary-to-BCD converter.
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // ceil(in_width * log10(2)); the product is never an exact integer for in_width > 0
  function automatic int min_bcd_digits(input int in_width);
    return (in_width * 30103 + 99999) / 100000;
  endfunction
endpackage

// File: rtl/bin_to_bcd_converter_if.sv
// Request/result bundle between the display-word source and the converter.
interface bin_to_bcd_converter_if
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int NUM_DIGITS = 10
);
  logic [IN_WIDTH-1:0]               number_in;
  logic                              start;
  logic                              busy;
  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd_out;
  logic                              bcd_valid;
  logic                              overflow;

  modport master (
    output number_in, start,
    input  busy, bcd_out, bcd_valid, overflow
  );

  modport slave (
    input  number_in, start,
    output busy, bcd_out, bcd_valid, overflow
  );
endinterface

// File: rtl/bin_to_bcd_converter_digit_adjust.sv
// Double-dabble digit correction: +3 when the digit is 5 or more, 4-bit wrap.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);
  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end
endmodule

// File: rtl/bin_to_bcd_converter.sv
// Iterative double-dabble converter, one shift per clock; the published result
// only changes on the completing edge so the display never sees partial digits.
module bin_to_bcd_converter
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH    = 32,
  parameter int NUM_DIGITS  = 10,
  parameter int DISP_DIGITS = 8,
  parameter bit AUTO_START  = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  bin_to_bcd_converter_if.slave  bus
);
  localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

  if (NUM_DIGITS < min_bcd_digits(IN_WIDTH)) begin : g_digits_chk
    $error("NUM_DIGITS too small for IN_WIDTH");
  end

  state_t                         state_q, state_d;
  logic [IN_WIDTH-1:0]            op_q, op_d;
  logic [IN_WIDTH-1:0]            last_q, last_d;
  bcd_digit_t [NUM_DIGITS-1:0]    scr_q, scr_d;
  bcd_digit_t [NUM_DIGITS-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           vld_q, vld_d;
  logic                           ovf_q, ovf_d;

  bcd_digit_t [NUM_DIGITS-1:0]    adj;
  bcd_digit_t [NUM_DIGITS-1:0]    sh_scr;
  logic [IN_WIDTH-1:0]            sh_op;
  logic                           sh_ovf;
  logic                           go;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (scr_q[i]),
      .dout (adj[i])
    );
  end

  always_comb begin
    // Operand MSB falls into scratch digit 0; the shifted-out scratch MSB is dropped.
    {sh_scr, sh_op} = {adj, op_q} << 1;
    sh_ovf = 1'b0;
    for (int i = DISP_DIGITS; i < NUM_DIGITS; i++) begin
      sh_ovf = sh_ovf | (sh_scr[i] != '0);
    end
    go = bus.start | (AUTO_START & (bus.number_in != last_q));
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    last_d  = last_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = SHIFT;
          op_d    = bus.number_in;
          last_d  = bus.number_in;
          scr_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        scr_d = sh_scr;
        op_d  = sh_op;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          bcd_d   = sh_scr;
          ovf_d   = sh_ovf;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      last_q  <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      last_q  <= last_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.bcd_out   = bcd_q;
  assign bus.bcd_valid = vld_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed bench: two converters (manual start / auto-start) with a result scoreboard each.
module tb_bin_to_bcd_converter;
  localparam int IW = 32;
  localparam int ND = 10;

  typedef struct {
    logic [4*ND-1:0] bcd;
    logic            ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   fails   = 0;
  int   v0_cnt  = 0;
  int   v1_cnt  = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  bin_to_bcd_converter_if #(.IN_WIDTH(IW), .NUM_DIGITS(ND)) m0 ();
  bin_to_bcd_converter_if #(.IN_WIDTH(IW), .NUM_DIGITS(ND)) m1 ();

  bin_to_bcd_converter #(.IN_WIDTH(IW), .NUM_DIGITS(ND), .DISP_DIGITS(8), .AUTO_START(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(m0.slave));
  bin_to_bcd_converter #(.IN_WIDTH(IW), .NUM_DIGITS(ND), .DISP_DIGITS(8), .AUTO_START(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(m1.slave));

  // Reference: repeated divide-by-ten, independent of the shift/add algorithm
  function automatic logic [4*ND-1:0] model(input logic [IW-1:0] v);
    logic [4*ND-1:0] r;
    logic [IW-1:0]   x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic [IW-1:0] v);
    exp_t e;
    e.bcd = model(v);
    e.ovf = (v >= 32'd100000000);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m0.bcd_valid === 1'b1) begin
      v0_cnt++;
      chk("dut0_result_pending", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("dut0_bcd_out", 64'(m0.bcd_out), 64'(e.bcd));
        chk("dut0_overflow", 64'(m0.overflow), 64'(e.ovf));
      end
    end
    if (m1.bcd_valid === 1'b1) begin
      v1_cnt++;
      chk("dut1_result_pending", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("dut1_bcd_out", 64'(m1.bcd_out), 64'(e.bcd));
        chk("dut1_overflow", 64'(m1.overflow), 64'(e.ovf));
      end
    end
  end

  task automatic wait_valid(input int which, input string tag, output int n);
    n = 0;
    while (((which == 0) ? m0.bcd_valid : m1.bcd_valid) !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_no_timeout"}, 64'(n < 100), 64'd1);
  endtask

  // Manual-start conversion on dut0 with latency and busy-width checks
  task automatic conv0(input logic [IW-1:0] v, input string tag);
    int n;
    int nbusy;
    m0.number_in = v;
    m0.start     = 1'b1;
    q0.push_back(mk_exp(v));
    tick();
    m0.start = 1'b0;
    n     = 0;
    nbusy = 0;
    while (m0.bcd_valid !== 1'b1 && n < 100) begin
      if (m0.busy === 1'b1) nbusy++;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd32);
    chk({tag, "_busy_cycles"}, 64'(nbusy), 64'd32);
    chk({tag, "_busy_low_at_valid"}, 64'(m0.busy), 64'd0);
    tick();
    chk({tag, "_valid_one_cycle"}, 64'(m0.bcd_valid), 64'd0);
  endtask

  initial begin
    int n;
    int c0;
    int c1;
    exp_t e;

    reset        = 1'b1;
    m0.number_in = '0;
    m0.start     = 1'b0;
    m1.number_in = '0;
    m1.start     = 1'b0;
    repeat (3) tick();

    chk("rst_busy0", 64'(m0.busy), 64'd0);
    chk("rst_bcd0", 64'(m0.bcd_out), 64'd0);
    chk("rst_valid0", 64'(m0.bcd_valid), 64'd0);
    chk("rst_ovf0", 64'(m0.overflow), 64'd0);
    chk("rst_busy1", 64'(m1.busy), 64'd0);
    chk("rst_bcd1", 64'(m1.bcd_out), 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("auto_quiet_on_zero", 64'(m1.busy), 64'd0);

    // Zero, mid-range, display-limit and overflow operands
    conv0(32'd0, "zero");
    conv0(32'd12345678, "d12345678");
    conv0(32'd99999999, "d99999999");
    conv0(32'd100000000, "d100000000");
    conv0(32'hFFFFFFFF, "dmax");

    // Manual mode: start while busy is dropped, no second result
    c0 = v0_cnt;
    m0.number_in = 32'd7;
    m0.start     = 1'b1;
    q0.push_back(mk_exp(32'd7));
    tick();
    m0.start = 1'b0;
    repeat (5) tick();
    m0.number_in = 32'd42;
    m0.start     = 1'b1;
    repeat (3) tick();
    m0.start = 1'b0;
    wait_valid(0, "busy_start0", n);
    repeat (50) tick();
    chk("busy_start0_pulses", 64'(v0_cnt - c0), 64'd1);

    // Auto mode: a change during busy is picked up after completion
    c1 = v1_cnt;
    m1.number_in = 32'd7;
    q1.push_back(mk_exp(32'd7));
    q1.push_back(mk_exp(32'd42));
    repeat (6) tick();
    m1.number_in = 32'd42;
    wait_valid(1, "auto_first", n);
    tick();
    wait_valid(1, "auto_second", n);
    tick();
    chk("auto_pulses", 64'(v1_cnt - c1), 64'd2);

    // Reset mid-conversion aborts without a result
    m0.number_in = 32'd5555;
    m0.start     = 1'b1;
    tick();
    m0.start = 1'b0;
    repeat (14) tick();
    chk("abort_busy_before", 64'(m0.busy), 64'd1);
    reset        = 1'b1;
    m0.number_in = '0;
    m1.number_in = '0;
    tick();
    chk("abort_busy", 64'(m0.busy), 64'd0);
    chk("abort_valid", 64'(m0.bcd_valid), 64'd0);
    chk("abort_bcd", 64'(m0.bcd_out), 64'd0);
    chk("abort_bcd1", 64'(m1.bcd_out), 64'd0);
    reset = 1'b0;
    c0 = v0_cnt;
    c1 = v1_cnt;
    repeat (40) tick();
    chk("abort_no_valid0", 64'(v0_cnt - c0), 64'd0);
    chk("abort_no_valid1", 64'(v1_cnt - c1), 64'd0);

    // Auto mode step sequence 0 -> 250 -> 250 -> 9
    c1 = v1_cnt;
    m1.number_in = 32'd250;
    q1.push_back(mk_exp(32'd250));
    wait_valid(1, "step250", n);
    tick();
    m1.number_in = 32'd250;
    repeat (20) tick();
    chk("step250_repeat_idle", 64'(m1.busy), 64'd0);
    chk("step250_repeat_pulses", 64'(v1_cnt - c1), 64'd1);
    m1.number_in = 32'd9;
    q1.push_back(mk_exp(32'd9));
    tick();
    n = 0;
    while (m1.busy === 1'b1 && n < 40) begin
      chk("hold_250", 64'(m1.bcd_out), 64'h250);
      tick();
      n++;
    end
    chk("step9_busy_cycles", 64'(n), 64'd32);
    chk("step9_valid", 64'(m1.bcd_valid), 64'd1);
    tick();
    chk("step_pulses", 64'(v1_cnt - c1), 64'd2);

    repeat (3) tick();
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
